// File: rtl/pipe_muldiv_ctrl.sv
// pipe_muldiv_ctrl: iterative multiply/divide sequencer beside the EXE stage.
// Runs shift-add multiply or restoring divide at one bit per cycle and owns HI/LO.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active-low
//   start    - mul/div-class op present in EXE this cycle
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//   rs_data  - operand A / dividend / MTHI-MTLO source
//   rt_data  - operand B / divisor
//   flush    - abort in-flight op; also squashes an op offered in the same cycle
//   stall    - hold IF/ID/EXE (combinational on accept, then held through CALC)
//   done     - one-cycle pulse in FIN when HI/LO take a mul/div result
//   hi, lo   - HI/LO registers
module pipe_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     ma_q, ma_d;      // |A| (multiplicand, or |dividend| for div-by-zero)
  logic [WIDTH-1:0]     mb_q, mb_d;      // |B| (divisor for div)
  logic [2*WIDTH-1:0]   p_q, p_d;        // {acc/remainder, multiplier/dividend-quotient}
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d; // negate product or quotient
  logic                 neg_r_q, neg_r_d; // negate remainder
  logic                 dvz_q, dvz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Decode of the offered op
  logic             is_muldiv;
  logic             op_signed;
  logic             sa, sb;
  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign is_muldiv = ~op[2];
  assign op_signed = ~op[0];
  assign sa        = op_signed & rs_data[WIDTH-1];
  assign sb        = op_signed & rt_data[WIDTH-1];
  assign abs_a     = sa ? (~rs_data + 1'b1) : rs_data;
  assign abs_b     = sb ? (~rt_data + 1'b1) : rt_data;
  assign accept    = (state_q == StIdle) & start & ~flush & is_muldiv;

  // One multiply step: add |A| when the current multiplier bit is set, shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? ma_q : '0)};
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign div_diff = {1'b0, p_q[2*WIDTH-1:WIDTH-1]} - {2'b00, mb_q};
  assign div_next = div_diff[WIDTH+1] ? {p_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  // Sign fix-ups applied when the result is written in FIN
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, dvz_hi;
  assign prod_fix = neg_q_q ? (~p_q + 1'b1) : p_q;
  assign quo_fix  = neg_q_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
  assign rem_fix  = neg_r_q ? (~p_q[2*WIDTH-1:WIDTH] + 1'b1) : p_q[2*WIDTH-1:WIDTH];
  // Restores the dividend exactly as latched: neg_r_q is set only for a negative signed one.
  assign dvz_hi   = neg_r_q ? (~ma_q + 1'b1) : ma_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    p_d      = p_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvz_d    = dvz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ma_d     = abs_a;
          mb_d     = abs_b;
          is_div_d = op[1];
          neg_q_d  = sa ^ sb;
          neg_r_d  = sa;
          dvz_d    = (rt_data == '0);
          p_d      = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          cnt_d    = '0;
          state_d  = StCalc;
        end else if (start && !flush && op == OpMthi) begin
          hi_d = rs_data;
        end else if (start && !flush && op == OpMtlo) begin
          lo_d = rs_data;
        end
      end
      StCalc: begin
        p_d   = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!flush) begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dvz_q) begin
            hi_d = dvz_hi;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      p_q      <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      p_q      <= p_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dvz_q    <= dvz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign stall = accept | (state_q == StCalc);
  assign done  = (state_q == StFin) & ~flush;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Self-checking bench for pipe_muldiv_ctrl (WIDTH = 32): directed table, random ops
// against an arithmetic reference model, and hand-written flush/reset/MTHI sequences.
module tb_pipe_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    res = '0;
    case (o)
      3'd0: begin p = sa * sb; res = p; end
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Issue one mul/div at posedge+1, hold start (with a decoy MTHI) through the stall,
  // and check stall length, done pulse, unchanged HI during CALC, and the result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hilo, input string name);
    int          cyc;
    logic [31:0] old_hi;
    old_hi  = hi;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    #1;
    check({name, " accept stall"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    op = 3'b100;
    cyc = 1;
    while (stall === 1'b1 && cyc < 100) begin
      rs_data = $urandom;
      rt_data = $urandom;
      cyc++;
      @(posedge clk); #1;
    end
    check({name, " stall cycles"}, 64'(cyc), 64'd33);
    check({name, " done in FIN"}, 64'(done), 64'd1);
    check({name, " hi held in CALC"}, 64'(hi), 64'(old_hi));
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " hi/lo"}, {hi, lo}, exp_hilo);
    check({name, " done low after"}, 64'(done), 64'd0);
  endtask

  vec_t        tbl[$];
  logic [63:0] exp;
  logic [31:0] a, b, hold_hi, hold_lo;
  logic [2:0]  o;
  int          guard;

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0; flush = 1'b0;

    tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "MULTU max"});
    tbl.push_back('{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "MULT -3*5"});
    tbl.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "DIV -7/2"});
    tbl.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "DIV 7/-2"});
    tbl.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "DIVU 100/7"});
    tbl.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "DIV ovf"});
    tbl.push_back('{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "DIVU 5/0"});
    tbl.push_back('{3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "DIV -5/0"});
    tbl.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "MULT minsq"});

    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    #16 rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, tbl[i].name);

    // MTHI then MTLO back to back: no stall, each visible one edge later
    start = 1'b1; op = 3'b100; rs_data = 32'h1234; #1;
    check("MTHI stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("MTHI hi", 64'(hi), 64'h1234);
    op = 3'b101; rs_data = 32'h5678; #1;
    check("MTLO stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("MTLO lo", 64'(lo), 64'h5678);
    check("MTLO hi kept", 64'(hi), 64'h1234);

    // Undefined op code is a no-op
    start = 1'b1; op = 3'b110; rs_data = 32'hDEAD_BEEF; rt_data = 32'h3; #1;
    check("undef stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("undef hi/lo", {hi, lo}, {32'h1234, 32'h5678});

    // Flush with start in IDLE squashes MTHI and mul/div
    start = 1'b1; op = 3'b100; rs_data = 32'hAAAA_0000; flush = 1'b1; #1;
    check("flush MTHI stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("flush MTHI hi", 64'(hi), 64'h1234);
    op = 3'b001; rs_data = 32'd9; rt_data = 32'd9; #1;
    check("flush MULTU stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; #1;
    check("flush MULTU idle", 64'(stall), 64'd0);

    // Flush at CALC iteration 10
    start = 1'b1; op = 3'b000; rs_data = 32'd1000; rt_data = 32'd1000; #1;
    check("flushcalc accept", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flushcalc in CALC", 64'(stall), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushcalc stall", 64'(stall), 64'd0);
    check("flushcalc done", 64'(done), 64'd0);
    check("flushcalc hi/lo", {hi, lo}, {32'h1234, 32'h5678});
    run_op(3'd0, 32'd6, 32'hFFFF_FFF9, model(3'd0, 32'd6, 32'hFFFF_FFF9), "MULT after flush");

    // Flush in the FIN cycle
    hold_hi = hi; hold_lo = lo;
    start = 1'b1; op = 3'b011; rs_data = 32'd77; rt_data = 32'd5; #1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (stall === 1'b1 && guard < 100) begin guard++; @(posedge clk); #1; end
    check("flushfin reached FIN", 64'(guard), 64'd32);
    flush = 1'b1; #1;
    check("flushfin done", 64'(done), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushfin hi/lo", {hi, lo}, {hold_hi, hold_lo});
    check("flushfin stall", 64'(stall), 64'd0);
    check("flushfin done after", 64'(done), 64'd0);
    run_op(3'd1, 32'd3, 32'd4, 64'd12, "MULTU after flushfin");

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, exp, $sformatf("rand%0d op%0d", i, o));
    end

    // Asynchronous reset in the middle of CALC
    start = 1'b1; op = 3'b001; rs_data = 32'd123; rt_data = 32'd456; #1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre-reset hi/lo nonzero", 64'({hi, lo} != 64'd0), 64'd1);
    rst = 1'b0; #1;
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset stall", 64'(stall), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd1, 32'd123, 32'd456, 64'd56088, "MULTU after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_muldiv_ctrl.md
Name: pipe_muldiv_ctrl

Overview:
Sequencer for an iterative multiply/divide unit beside the EXE stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE and runs shift-add multiply or restoring divide, one bit per cycle. It stalls the pipeline while busy and owns the HI/LO registers that feed the EXE-to-MEM path.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  valid mul/div-class op present in EXE this cycle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
rs_data  input  WIDTH  operand A / dividend / MTHI-MTLO source
rt_data  input  WIDTH  operand B / divisor
flush  input  1  abort in-flight op (branch/exception squash)
stall  output  1  hold IF/ID/EXE this cycle
done  output  1  one-cycle pulse: HI/LO updated by a mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE, hi=0, lo=0, done=0, stall=0, counter=0, internal operands cleared.
- States: IDLE, CALC, FIN.
- IDLE:
  - start & op in {MULT,MULTU,DIV,DIVU}: latch operands, go to CALC, counter=0.
  - stall is combinational and is 1 in this same cycle, so EXE holds the instruction.
  - start & MTHI: hi<=rs_data at the next edge. MTLO: lo<=rs_data. No stall, stay IDLE.
  - Undefined op codes are ignored.
- CALC: stall=1. One iteration per cycle. Counter increments; after WIDTH iterations (counter==WIDTH-1 at the edge) go to FIN.
- FIN: hi/lo written at the FIN edge, done=1 during FIN, stall=0, then IDLE.
- Total stall = WIDTH+1 cycles (1 accept + WIDTH CALC). The instruction leaves EXE in the FIN cycle.
- MULT/MULTU:
  - 2*WIDTH-bit product; hi=upper WIDTH bits, lo=lower.
  - Signed: iterate on magnitudes, then negate the 2W-bit result if signs differ.
- DIV/DIVU:
  - lo=quotient, hi=remainder. Signed: quotient sign = sa^sb; remainder sign = sign of dividend.
  - Divide by zero: no exception; lo=all ones, hi=dividend (rs_data as latched).
  - Signed overflow (-2^(W-1) / -1): lo=-2^(W-1), hi=0.
- start is ignored while in CALC/FIN; the upstream instruction is held by stall.
- flush:
  - In any state: return to IDLE at the next edge, hi/lo unchanged, done=0. Flush has priority over a FIN write.
  - flush with start in IDLE: op not accepted; MTHI/MTLO also suppressed.
- Operands latched at accept; later rs_data/rt_data changes do not affect the result.
- hi/lo reads during CALC return the old values. Consumers are stalled, so no forwarding is required.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- Reset: rst=0 mid-CALC -> hi=lo=0, stall=0 asynchronously. Release -> IDLE, start accepted next cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall high 33 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, normal 33-cycle stall.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> stall never asserted, hi=0x1234, lo=0x5678 one edge after each.
- flush at CALC iteration 10, and flush in the FIN cycle -> IDLE next edge, hi/lo keep their prior values, done=0. New MULT accepted the following cycle.
